// File: rtl/vc_arbiter_if.sv
// Bundle of the arbiter's FIFO-side, downstream-side and status signals.
// The arbiter connects through the slave modport; the environment (FIFOs,
// demux, bench) drives through the master modport.
interface vc_arbiter_if;
  logic       vc0_empty;
  logic       vc1_empty;
  logic [5:0] vc0_data;
  logic [5:0] vc1_data;
  logic       pause_d0;
  logic       pause_d1;
  logic       pop_vc0;
  logic       pop_vc1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       dest_out;
  logic [1:0] state;

  modport slave (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
    output pop_vc0, pop_vc1, data_out, valid_out, dest_out, state
  );

  modport master (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
    input  pop_vc0, pop_vc1, data_out, valid_out, dest_out, state
  );
endinterface

// File: rtl/vc_arbiter.sv
// Two-VC weighted arbiter: pops one word per cycle from VC0/VC1, VC0 favoured
// but VC1 guaranteed a slot after VC0_WEIGHT consecutive VC0 grants while it
// waits. Popped words reach the demux two cycles after the pop.
module vc_arbiter #(
  parameter int VC0_WEIGHT = 4
) (
  input  logic        clk,
  input  logic        reset_L,
  vc_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [3:0] WMAX = 4'(VC0_WEIGHT);

  logic       stall;
  logic       vc0_avail;
  logic       vc1_avail;
  logic       pop0;
  logic       pop1;
  logic [3:0] wcnt_q, wcnt_d;
  logic       pend_valid_q;
  logic       pend_src_q;
  logic [5:0] sel_word;
  logic [5:0] data_q;
  logic       valid_q;
  logic       dest_q;
  logic [1:0] state_q, state_d;

  // Either downstream FIFO near full halts new pops; in-flight words still drain.
  assign stall     = bus.pause_d0 | bus.pause_d1;
  assign vc0_avail = ~bus.vc0_empty;
  assign vc1_avail = ~bus.vc1_empty;

  // Empty flags are used combinationally so a FIFO emptying this cycle is never popped.
  assign pop0 = reset_L & ~stall & vc0_avail & ~(vc1_avail & (wcnt_q == WMAX));
  assign pop1 = reset_L & ~stall & vc1_avail & ~pop0;

  assign bus.pop_vc0   = pop0;
  assign bus.pop_vc1   = pop1;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.dest_out  = dest_q;
  assign bus.state     = state_q;

  // Word returned by the FIFO that was popped last cycle.
  assign sel_word = pend_src_q ? bus.vc1_data : bus.vc0_data;

  // Fairness counter: counts VC0 grants only while VC1 is waiting.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!stall) begin
      if (pop1 || !vc1_avail)
        wcnt_d = 4'd0;
      else if (pop0)
        wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Next-state logic for the IDLE/SERVE/PAUSE status FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (stall)
          state_d = PAUSE;
        else if (vc0_avail || vc1_avail)
          state_d = SERVE;
      end
      SERVE: begin
        if (stall)
          state_d = PAUSE;
        else if (!vc0_avail && !vc1_avail && !pend_valid_q)
          state_d = IDLE;
      end
      PAUSE: begin
        if (!stall)
          state_d = (vc0_avail || vc1_avail) ? SERVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pop pipeline and output registers; reset drops any pending word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wcnt_q       <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_src_q   <= 1'b0;
      data_q       <= 6'd0;
      valid_q      <= 1'b0;
      dest_q       <= 1'b0;
      state_q      <= IDLE;
    end else begin
      wcnt_q       <= wcnt_d;
      state_q      <= state_d;
      pend_valid_q <= pop0 | pop1;
      pend_src_q   <= pop1;
      valid_q      <= pend_valid_q;
      if (pend_valid_q) begin
        data_q <= sel_word;
        dest_q <= sel_word[4];
      end
    end
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter VC0_WEIGHT, default 4, range 1..15: maximum consecutive VC0 grants while VC1 is waiting.
REQ-002 clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 reset_L  input  1  reset, asynchronous and active-low.
REQ-004 vc0_empty  input  1  VC0 FIFO holds no word.
REQ-005 vc1_empty  input  1  VC1 FIFO holds no word.
REQ-006 vc0_data  input  6  VC0 FIFO read data, valid the cycle after pop_vc0.
REQ-007 vc1_data  input  6  VC1 FIFO read data, valid the cycle after pop_vc1.
REQ-008 pause_d0  input  1  downstream D0 FIFO almost full.
REQ-009 pause_d1  input  1  downstream D1 FIFO almost full.
REQ-010 pop_vc0  output  1  combinational read strobe to the VC0 FIFO.
REQ-011 pop_vc1  output  1  combinational read strobe to the VC1 FIFO.
REQ-012 data_out  output  6  registered word to the demux.
REQ-013 valid_out  output  1  registered; data_out is valid this cycle.
REQ-014 dest_out  output  1  registered; equals data_out[4] (0 = D0, 1 = D1).
REQ-015 state  output  2  current FSM state: IDLE=0, SERVE=1, PAUSE=2.

Function
REQ-016 stall SHALL be pause_d0 OR pause_d1; no pop SHALL be issued in any cycle where stall=1 or reset_L=0.
REQ-017 pop_vc0 and pop_vc1 SHALL never be asserted in the same cycle.
REQ-018 Without stall, pop_vc0=1 if VC0 is non-empty and not (VC1 non-empty and wcnt==VC0_WEIGHT).
REQ-019 Without stall, pop_vc1=1 if VC1 is non-empty and pop_vc0=0.
REQ-020 wcnt (4 bits): +1 on a pop_vc0 while VC1 is non-empty; cleared on pop_vc1 or when VC1 is empty; held on stall cycles; never exceeds VC0_WEIGHT.
REQ-021 Pipeline: a pop in cycle N sets pend_valid and pend_src for cycle N+1. At the edge ending N+1, data_out SHALL capture pend_src ? vc1_data : vc0_data, and valid_out=1 in cycle N+2 (2-cycle latency).
REQ-022 valid_out SHALL be 0 in any cycle not preceded by a pending word; data_out holds its last value when valid_out=0.
REQ-023 A word already popped SHALL complete delivery even if stall rises after the pop (pause thresholds absorb 2 words).
REQ-024 FSM: IDLE->SERVE when any VC is non-empty and not stall; IDLE->PAUSE on stall.
REQ-025 FSM: SERVE->PAUSE on stall; SERVE->IDLE when both VCs are empty and no word is pending.
REQ-026 FSM: PAUSE->SERVE when stall=0 and any VC is non-empty; PAUSE->IDLE when stall=0 and both are empty.
REQ-027 A FIFO's empty input rising in the same cycle it is being considered SHALL suppress that pop (empty is sampled combinationally).

Reset
REQ-028 With reset_L=0, all registers SHALL clear asynchronously: data_out=0, valid_out=0, dest_out=0, state=IDLE, wcnt=0, pend_valid=0; pop outputs are 0.
REQ-029 Reset asserted mid-transfer SHALL discard any pending word; after release, the first pop SHALL be possible in the first cycle with reset_L=1.

Verification
REQ-030 Only VC0 non-empty, containing 0x2A, 0x2C, 0x2E; no pause -> pop_vc0 on 3 consecutive cycles; valid_out=1 with 0x2A, 0x2C, 0x2E starting 2 cycles after the first pop; dest_out = 0, 0, 0.
REQ-031 Both VCs continuously non-empty, VC0_WEIGHT=4 -> repeating grant pattern of 4 VC0 pops then 1 VC1 pop; wcnt runs 0..4 and then clears.
REQ-032 pause_d1 rises during streaming -> no pop from the next cycle; the 2 in-flight words still emerge; state=PAUSE; popping resumes the cycle pause_d1 falls.
REQ-033 Only VC1 non-empty, containing 0x15 (bit4=1) -> pop_vc1 once; 2 cycles later data_out=0x15, dest_out=1; then state returns to IDLE.
REQ-034 reset_L driven low for one half-period during SERVE with a word pending -> outputs zero immediately; no valid_out for the discarded word after release.
REQ-035 Both VCs empty, with pause toggled -> no pops; valid_out stays 0; state moves IDLE->PAUSE->IDLE.
